led_seq_ctrl: RTL and testbench
===============================

LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000, clk cycles per tick (1 ms at 50 MHz).
REQ-002 SHALL have parameter PERIOD_RST, default 250, reset value of PERIOD register in ticks.
REQ-003 SHALL have one clock and an asynchronous, active-low reset; reset is fixed at that polarity and synchronicity.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 avs_s0_address  input  2  register word address.
REQ-007 avs_s0_read  input  1  read strobe.
REQ-008 avs_s0_write  input  1  write strobe.
REQ-009 avs_s0_readdata  output  32  read data.
REQ-010 avs_s0_writedata  input  32  write data.
REQ-011 btn_i  input  4  raw board buttons, active-low, asynchronous.
REQ-012 led_o  output  8  LED drive, registered.

Function
REQ-013 Register map: 0 CTRL rw, [0] enable, [1] mode (0 manual, 1 auto), [3:2] pattern; 1 PERIOD rw, [15:0]; 2 MANUAL rw, [7:0]; 3 STATUS ro except W1C bit.
REQ-014 STATUS: [7:0] led_o, [9:8] state code, [13:10] synchronized button levels (1 = pressed), [16] sticky press flag, W1C; all other bits read 0.
REQ-015 Fixed read latency 1: readdata valid on the cycle after read; unused register bits read 0; readdata holds last value otherwise.
REQ-016 Writes take effect on the cycle after write; unused writedata bits ignored.
REQ-017 Prescaler counts 0..TICK_DIV-1 and emits a 1-cycle tick at wrap; step counter counts ticks to PERIOD and emits a 1-cycle step; PERIOD=0 treated as 1.
REQ-018 States: IDLE(0), MANUAL(1), RUN(2), PAUSE(3).
REQ-019 enable=0 -> IDLE from any state, led_o=0x00.
REQ-020 enable=1, mode=0 -> MANUAL; led_o follows MANUAL register one cycle after write.
REQ-021 enable=1, mode=1 from IDLE/MANUAL -> RUN; pattern seed loaded; prescaler and step counter cleared.
REQ-022 btn_i[0] press (synchronized falling edge) toggles RUN<->PAUSE; ignored in IDLE/MANUAL; PAUSE freezes led_o and both counters.
REQ-023 Any press of any button sets STATUS[16]; a simultaneous set and W1C leaves it set.
REQ-024 Patterns on each step in RUN:
 - 0 rotate-left, seed 0x01, 0x80 -> 0x01.
 - 1 bounce, seed 0x01 going up, reverses at 0x80 and at 0x01.
 - 2 counter, seed 0x00, +1 mod 256.
 - 3 blink, seed MANUAL, alternates value and its complement.
REQ-025 CTRL write changing pattern while RUN/PAUSE reloads seed, clears counters, keeps state.
REQ-026 CTRL write and button press in the same cycle: write applied, toggle discarded, STATUS[16] still set.

Reset
REQ-027 On reset_n low, asynchronously: CTRL=0, PERIOD=PERIOD_RST, MANUAL=0, STATUS[16]=0, state IDLE, counters 0, led_o=0x00, readdata=0, synchronizers 0 (not pressed).
REQ-028 Reset asserted mid-RUN aborts the sequence with no further step; after release the block stays IDLE until CTRL is written.

Structure
REQ-029 Package led_seq_pkg SHALL hold the state enum, pattern enum, register address constants and STATUS bit positions.
REQ-030 Sub-module btn_sync_edge (2-FF synchronizer, inversion, falling-edge pulse, width parameter) SHALL be instantiated once for all 4 buttons.

Verification (TICK_DIV=4)
REQ-031 Reset, then read all four registers -> CTRL 0, PERIOD 250, MANUAL 0, STATUS 0; led_o 0x00.
REQ-032 Write MANUAL=0xA5, CTRL=0x1 -> led_o 0xA5, STATUS[9:8]=1.
REQ-033 PERIOD=2, CTRL=0x3 (rotate) -> led_o 0x01, 0x02, 0x04 every 8 cycles; 0x80 -> 0x01.
REQ-034 CTRL=0x7 (bounce), run 16 steps -> 0x01..0x80..0x01, reversing at both ends with no repeated value.
REQ-035 In RUN press btn_i[0] -> PAUSE, led_o frozen; press again -> RUN; STATUS[16]=1; write STATUS bit16=1 -> reads 0.
REQ-036 Press btn_i[0] in the same cycle as CTRL write -> state unchanged by the button, STATUS[16]=1; reset_n low mid-RUN -> led_o 0x00 immediately.

Source files
------------

// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared types and constants for the LED sequencer.
//   state_t    - controller state, encoding is also the STATUS state code
//   pattern_t  - CTRL pattern field
//   ADDR_*     - register word addresses
//   CTRL_*/STAT_* - bit positions inside CTRL and STATUS
//   pattern_seed() - first LED value when a pattern (re)starts
package led_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MANUAL = 2'd1,
    ST_RUN    = 2'd2,
    ST_PAUSE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    PAT_ROTATE = 2'd0,
    PAT_BOUNCE = 2'd1,
    PAT_COUNT  = 2'd2,
    PAT_BLINK  = 2'd3
  } pattern_t;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PERIOD = 2'd1;
  localparam logic [1:0] ADDR_MANUAL = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int unsigned CTRL_ENABLE_BIT = 0;
  localparam int unsigned CTRL_MODE_BIT   = 1;
  localparam int unsigned CTRL_PAT_LSB    = 2;

  localparam int unsigned STAT_LED_LSB   = 0;
  localparam int unsigned STAT_STATE_LSB = 8;
  localparam int unsigned STAT_BTN_LSB   = 10;
  localparam int unsigned STAT_PRESS_BIT = 16;

  function automatic logic [7:0] pattern_seed(input pattern_t pat, input logic [7:0] manual);
    logic [7:0] seed;
    seed = 8'h01;
    unique case (pat)
      PAT_ROTATE, PAT_BOUNCE: seed = 8'h01;
      PAT_COUNT:              seed = 8'h00;
      PAT_BLINK:              seed = manual;
      default:                seed = 8'h01;
    endcase
    return seed;
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// btn_sync_edge: two-flop synchronizer for active-low raw buttons, with
// inversion and a one-cycle pulse on each press (falling edge of the raw pin).
//   clk     - clock
//   reset_n - asynchronous active-low reset (all flops clear = not pressed)
//   btn     - raw active-low button pins, asynchronous
//   level   - synchronized level, 1 = pressed
//   press   - one-cycle pulse when a button becomes pressed
module btn_sync_edge #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] btn,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] press
);

  logic [WIDTH-1:0] meta;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] prev;

  // Inversion happens at the first flop so the reset value means "not pressed".
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= '0;
      sync <= '0;
      prev <= '0;
    end else begin
      meta <= ~btn;
      sync <= meta;
      prev <= sync;
    end
  end

  assign level = sync;
  assign press = sync & ~prev;

endmodule

// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: Avalon-MM controlled LED sequencer.
//   clk, reset_n      - clock, asynchronous active-low reset
//   avs_s0_address    - register word address (CTRL, PERIOD, MANUAL, STATUS)
//   avs_s0_read       - read strobe, readdata valid the following cycle
//   avs_s0_write      - write strobe, register updates at the same edge
//   avs_s0_writedata  - write data
//   avs_s0_readdata   - registered read data, holds between reads
//   btn_i             - raw active-low buttons; btn_i[0] toggles RUN/PAUSE
//   led_o             - registered LED drive
module led_seq_ctrl
  import led_seq_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 50000,
  parameter int unsigned PERIOD_RST = 250
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  avs_s0_address,
  input  logic        avs_s0_read,
  input  logic        avs_s0_write,
  output logic [31:0] avs_s0_readdata,
  input  logic [31:0] avs_s0_writedata,
  input  logic [3:0]  btn_i,
  output logic [7:0]  led_o
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  logic        ctrl_enable;
  logic        ctrl_mode;
  pattern_t    ctrl_pattern;
  logic [15:0] period;
  logic [7:0]  manual;
  logic        press_flag;

  state_t      state, state_next;
  logic [PW-1:0] pre, pre_next;
  logic [15:0] step_cnt, step_cnt_next;
  logic [7:0]  led, led_next;
  logic        dir_up, dir_up_next;

  logic [3:0]  btn_level;
  logic [3:0]  btn_press;

  logic        wr_ctrl, wr_period, wr_manual, wr_status;
  pattern_t    wr_pattern, pat_sel;
  logic [7:0]  manual_eff;
  logic [15:0] period_eff;
  logic        tick, step, enter_run, reload;
  logic [31:0] rd_word;
  logic        unused_wdata;

  btn_sync_edge #(.WIDTH(4)) u_btn (
    .clk     (clk),
    .reset_n (reset_n),
    .btn     (btn_i),
    .level   (btn_level),
    .press   (btn_press)
  );

  assign wr_ctrl    = avs_s0_write && (avs_s0_address == ADDR_CTRL);
  assign wr_period  = avs_s0_write && (avs_s0_address == ADDR_PERIOD);
  assign wr_manual  = avs_s0_write && (avs_s0_address == ADDR_MANUAL);
  assign wr_status  = avs_s0_write && (avs_s0_address == ADDR_STATUS);
  assign wr_pattern = pattern_t'(avs_s0_writedata[CTRL_PAT_LSB +: 2]);
  assign unused_wdata = ^avs_s0_writedata[31:17];

  // A pattern or MANUAL value written this cycle is already the one to seed from.
  assign pat_sel    = wr_ctrl ? wr_pattern : ctrl_pattern;
  assign manual_eff = wr_manual ? avs_s0_writedata[7:0] : manual;
  assign period_eff = (period == 16'd0) ? 16'd1 : period;

  assign tick = (state == ST_RUN) && (pre == PRE_MAX);
  assign step = tick && (({1'b0, step_cnt} + 17'd1) >= {1'b0, period_eff});

  // Register file and read port
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_enable     <= 1'b0;
      ctrl_mode       <= 1'b0;
      ctrl_pattern    <= PAT_ROTATE;
      period          <= 16'(PERIOD_RST);
      manual          <= '0;
      press_flag      <= 1'b0;
      avs_s0_readdata <= '0;
    end else begin
      if (wr_ctrl) begin
        ctrl_enable  <= avs_s0_writedata[CTRL_ENABLE_BIT];
        ctrl_mode    <= avs_s0_writedata[CTRL_MODE_BIT];
        ctrl_pattern <= wr_pattern;
      end
      if (wr_period) period <= avs_s0_writedata[15:0];
      if (wr_manual) manual <= avs_s0_writedata[7:0];
      // Set has priority over write-1-to-clear.
      if (|btn_press)
        press_flag <= 1'b1;
      else if (wr_status && avs_s0_writedata[STAT_PRESS_BIT])
        press_flag <= 1'b0;
      if (avs_s0_read) avs_s0_readdata <= rd_word;
    end
  end

  always_comb begin
    rd_word = '0;
    unique case (avs_s0_address)
      ADDR_CTRL: begin
        rd_word[CTRL_ENABLE_BIT]       = ctrl_enable;
        rd_word[CTRL_MODE_BIT]         = ctrl_mode;
        rd_word[CTRL_PAT_LSB +: 2]     = ctrl_pattern;
      end
      ADDR_PERIOD: rd_word[15:0] = period;
      ADDR_MANUAL: rd_word[7:0]  = manual;
      ADDR_STATUS: begin
        rd_word[STAT_LED_LSB +: 8]   = led;
        rd_word[STAT_STATE_LSB +: 2] = state;
        rd_word[STAT_BTN_LSB +: 4]   = btn_level;
        rd_word[STAT_PRESS_BIT]      = press_flag;
      end
      default: rd_word = '0;
    endcase
  end

  // Controller state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      pre      <= '0;
      step_cnt <= '0;
      led      <= '0;
      dir_up   <= 1'b1;
    end else begin
      state    <= state_next;
      pre      <= pre_next;
      step_cnt <= step_cnt_next;
      led      <= led_next;
      dir_up   <= dir_up_next;
    end
  end

  // Next state; a CTRL write in the same cycle swallows the button toggle.
  always_comb begin
    state_next = state;
    if (!ctrl_enable)
      state_next = ST_IDLE;
    else if (!ctrl_mode)
      state_next = ST_MANUAL;
    else begin
      unique case (state)
        ST_IDLE, ST_MANUAL: state_next = ST_RUN;
        ST_RUN:   if (btn_press[0] && !wr_ctrl) state_next = ST_PAUSE;
        ST_PAUSE: if (btn_press[0] && !wr_ctrl) state_next = ST_RUN;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  // LED and counter datapath, keyed on the state being entered.
  always_comb begin
    enter_run = (state_next == ST_RUN) && ((state == ST_IDLE) || (state == ST_MANUAL));
    reload    = wr_ctrl && (wr_pattern != ctrl_pattern)
             && ((state == ST_RUN) || (state == ST_PAUSE))
             && ((state_next == ST_RUN) || (state_next == ST_PAUSE));
    pre_next      = pre;
    step_cnt_next = step_cnt;
    led_next      = led;
    dir_up_next   = dir_up;
    unique case (state_next)
      ST_IDLE, ST_MANUAL: begin
        led_next      = (state_next == ST_MANUAL) ? manual_eff : 8'h00;
        pre_next      = '0;
        step_cnt_next = '0;
        dir_up_next   = 1'b1;
      end
      default: begin
        if (enter_run || reload) begin
          led_next      = pattern_seed(pat_sel, manual_eff);
          pre_next      = '0;
          step_cnt_next = '0;
          dir_up_next   = 1'b1;
        end else if (state == ST_RUN) begin
          // Counters advance only while RUN; PAUSE leaves them as they are.
          pre_next = tick ? '0 : pre + 1'b1;
          if (tick) step_cnt_next = step ? 16'd0 : step_cnt + 16'd1;
          if (step) begin
            unique case (ctrl_pattern)
              PAT_ROTATE: led_next = {led[6:0], led[7]};
              PAT_BOUNCE: begin
                if (dir_up) begin
                  if (led[7]) begin
                    led_next    = led >> 1;
                    dir_up_next = 1'b0;
                  end else
                    led_next = led << 1;
                end else begin
                  if (led[0]) begin
                    led_next    = led << 1;
                    dir_up_next = 1'b1;
                  end else
                    led_next = led >> 1;
                end
              end
              PAT_COUNT: led_next = led + 8'd1;
              default:   led_next = ~led;
            endcase
          end
        end
      end
    endcase
  end

  assign led_o = led;

endmodule

// File: tb/tb_led_seq_ctrl.sv
module tb_led_seq_ctrl;

  localparam logic [1:0] A_CTRL = 2'd0, A_PERIOD = 2'd1, A_MANUAL = 2'd2, A_STATUS = 2'd3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        read, write;
  logic [31:0] readdata, writedata;
  logic [3:0]  btn;
  logic [7:0]  led;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  led_seq_ctrl #(.TICK_DIV(4), .PERIOD_RST(250)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .avs_s0_address   (address),
    .avs_s0_read      (read),
    .avs_s0_write     (write),
    .avs_s0_readdata  (readdata),
    .avs_s0_writedata (writedata),
    .btn_i            (btn),
    .led_o            (led)
  );

  // Expected-value models
  function automatic logic [7:0] rot_at(input int i);
    return 8'(1 << (i % 8));
  endfunction

  function automatic logic [7:0] bounce_at(input int k);
    int p;
    p = k % 14;
    if (p > 7) p = 14 - p;
    return 8'(1 << p);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    address = a; writedata = d; write = 1'b1;
    @(posedge clk); #1;
    write = 1'b0; writedata = '0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    address = a; read = 1'b1;
    @(posedge clk); #1;
    read = 1'b0;
    d = readdata;
  endtask

  task automatic test_reset();
    logic [31:0] rd, e;
    string nm[4];
    logic [31:0] rexp[4];
    nm = '{"rst_ctrl", "rst_period", "rst_manual", "rst_status"};
    rexp = '{32'h0, 32'd250, 32'h0, 32'h0};
    exp_q.push_back(32'h0);
    e = exp_q.pop_front(); n_checks++;
    if ({24'h0, led} !== e) begin n_fail++; $display("FAIL rst_led: got %h expected %h", led, e); end
    exp_q.push_back(32'h0);
    e = exp_q.pop_front(); n_checks++;
    if (readdata !== e) begin n_fail++; $display("FAIL rst_readdata: got %h expected %h", readdata, e); end
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(rexp[i]);
      bus_read(2'(i), rd);
      e = exp_q.pop_front(); n_checks++;
      if (rd !== e) begin n_fail++; $display("FAIL %s: got %h expected %h", nm[i], rd, e); end
    end
  endtask

  task automatic test_manual();
    logic [31:0] rd, e;
    bus_write(A_MANUAL, 32'hFFFF_FFA5);
    bus_write(A_CTRL, 32'h1);
    exp_q.push_back(32'hA5);
    tick(1);
    e = exp_q.pop_front(); n_checks++;
    if ({24'h0, led} !== e) begin n_fail++; $display("FAIL manual_led: got %h expected %h", led, e); end
    exp_q.push_back(32'h0000_01A5);
    bus_read(A_STATUS, rd);
    e = exp_q.pop_front(); n_checks++;
    if (rd !== e) begin n_fail++; $display("FAIL manual_status: got %h expected %h", rd, e); end
    exp_q.push_back(32'hA5);
    bus_read(A_MANUAL, rd);
    e = exp_q.pop_front(); n_checks++;
    if (rd !== e) begin n_fail++; $display("FAIL manual_reg: got %h expected %h", rd, e); end
    exp_q.push_back(32'h1);
    bus_read(A_CTRL, rd);
    e = exp_q.pop_front(); n_checks++;
    if (rd !== e) begin n_fail++; $display("FAIL ctrl_reg: got %h expected %h", rd, e); end
    exp_q.push_back(32'h3C);
    bus_write(A_MANUAL, 32'h3C);
    e = exp_q.pop_front(); n_checks++;
    if ({24'h0, led} !== e) begin n_fail++; $display("FAIL manual_follow: got %h expected %h", led, e); end
  endtask

  task automatic test_rotate();
    logic [31:0] rd, e;
    bus_write(A_PERIOD, 32'hABCD_0002);
    exp_q.push_back(32'h2);
    bus_read(A_PERIOD, rd);
    e = exp_q.pop_front(); n_checks++;
    if (rd !== e) begin n_fail++; $display("FAIL period_reg: got %h expected %h", rd, e); end
    bus_write(A_CTRL, 32'h3);
    exp_q.push_back({24'h0, rot_at(0)});
    tick(1);
    e = exp_q.pop_front(); n_checks++;
    if ({24'h0, led} !== e) begin n_fail++; $display("FAIL rotate_seed: got %h expected %h", led, e); end
    for (int i = 1; i <= 9; i++) begin
      exp_q.push_back({24'h0, rot_at(i - 1)});
      exp_q.push_back({24'h0, rot_at(i)});
      tick(7);
      e = exp_q.pop_front(); n_checks++;
      if ({24'h0, led} !== e) begin n_fail++; $display("FAIL rotate_hold%0d: got %h expected %h", i, led, e); end
      tick(1);
      e = exp_q.pop_front(); n_checks++;
      if ({24'h0, led} !== e) begin n_fail++; $display("FAIL rotate_step%0d: got %h expected %h", i, led, e); end
    end
  endtask

  task automatic test_bounce();
    logic [31:0] e;
    exp_q.push_back({24'h0, bounce_at(0)});
    bus_write(A_CTRL, 32'h7);
    e = exp_q.pop_front(); n_checks++;
    if ({24'h0, led} !== e) begin n_fail++; $display("FAIL bounce_seed: got %h expected %h", led, e); end
    for (int k = 1; k <= 16; k++) begin
      exp_q.push_back({24'h0, bounce_at(k - 1)});
      exp_q.push_back({24'h0, bounce_at(k)});
      tick(7);
      e = exp_q.pop_front(); n_checks++;
      if ({24'h0, led} !== e) begin n_fail++; $display("FAIL bounce_hold%0d: got %h expected %h", k, led, e); end
      tick(1);
      e = exp_q.pop_front(); n_checks++;
      if ({24'h0, led} !== e) begin n_fail++; $display("FAIL bounce_step%0d: got %h expected %h", k, led, e); end
    end
  endtask

  // Starts right on a step edge left by test_bounce (led = bounce_at(16)).
  task automatic test_pause();
    logic [31:0] rd, e;
    btn[0] = 1'b0;
    exp_q.push_back({24'h0, bounce_at(16)});
    tick(3);
    e = exp_q.pop_front(); n_checks++;
    if ({24'h0, led} !== e) begin n_fail++; $display("FAIL pause_enter: got %h expected %h", led, e); end
    tick(2);
    btn[0] = 1'b1;
    exp_q.push_back({24'h0, bounce_at(16)});
    tick(5);
    e = exp_q.pop_front(); n_checks++;
    if ({24'h0, led} !== e) begin n_fail++; $display("FAIL pause_frozen: got %h expected %h", led, e); end
    exp_q.push_back(32'h0001_0300 | {24'h0, bounce_at(16)});
    bus_read(A_STATUS, rd);
    e = exp_q.pop_front(); n_checks++;
    if (rd !== e) begin n_fail++; $display("FAIL pause_status: got %h expected %h", rd, e); end
    btn[0] = 1'b0;
    exp_q.push_back({24'h0, bounce_at(16)});
    exp_q.push_back({24'h0, bounce_at(17)});
    tick(3);
    tick(4);
    e = exp_q.pop_front(); n_checks++;
    if ({24'h0, led} !== e) begin n_fail++; $display("FAIL resume_hold: got %h expected %h", led, e); end
    tick(1);
    e = exp_q.pop_front(); n_checks++;
    if ({24'h0, led} !== e) begin n_fail++; $display("FAIL resume_step: got %h expected %h", led, e); end
    btn[0] = 1'b1;
    tick(4);
    bus_write(A_STATUS, 32'h0001_0000);
    exp_q.push_back(32'b0_10);
    bus_read(A_STATUS, rd);
    e = exp_q.pop_front(); n_checks++;
    if ({29'h0, rd[16], rd[9:8]} !== e) begin n_fail++; $display("FAIL w1c_status: got %h expected %h", {rd[16], rd[9:8]}, e[2:0]); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, e;
    btn[0] = 1'b0;
    tick(1);
    bus_write(A_CTRL, 32'h7);
    btn[0] = 1'b1;
    tick(3);
    exp_q.push_back(32'b1_10);
    bus_read(A_STATUS, rd);
    e = exp_q.pop_front(); n_checks++;
    if ({29'h0, rd[16], rd[9:8]} !== e) begin n_fail++; $display("FAIL same_cycle: got %h expected %h", {rd[16], rd[9:8]}, e[2:0]); end
  endtask

  task automatic test_counter_blink();
    logic [31:0] e;
    bus_write(A_PERIOD, 32'h0);
    exp_q.push_back(32'h00);
    bus_write(A_CTRL, 32'hB);
    e = exp_q.pop_front(); n_checks++;
    if ({24'h0, led} !== e) begin n_fail++; $display("FAIL count_seed: got %h expected %h", led, e); end
    for (int k = 1; k <= 5; k++) begin
      exp_q.push_back(32'(k - 1));
      exp_q.push_back(32'(k));
      tick(3);
      e = exp_q.pop_front(); n_checks++;
      if ({24'h0, led} !== e) begin n_fail++; $display("FAIL count_hold%0d: got %h expected %h", k, led, e); end
      tick(1);
      e = exp_q.pop_front(); n_checks++;
      if ({24'h0, led} !== e) begin n_fail++; $display("FAIL count_step%0d: got %h expected %h", k, led, e); end
    end
    exp_q.push_back(32'h3C);
    bus_write(A_CTRL, 32'hF);
    e = exp_q.pop_front(); n_checks++;
    if ({24'h0, led} !== e) begin n_fail++; $display("FAIL blink_seed: got %h expected %h", led, e); end
    for (int k = 1; k <= 2; k++) begin
      exp_q.push_back((k % 2 == 1) ? 32'hC3 : 32'h3C);
      tick(4);
      e = exp_q.pop_front(); n_checks++;
      if ({24'h0, led} !== e) begin n_fail++; $display("FAIL blink_step%0d: got %h expected %h", k, led, e); end
    end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] rd, e;
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    exp_q.push_back(32'h0);
    e = exp_q.pop_front(); n_checks++;
    if ({24'h0, led} !== e) begin n_fail++; $display("FAIL async_rst_led: got %h expected %h", led, e); end
    exp_q.push_back(32'h0);
    e = exp_q.pop_front(); n_checks++;
    if (readdata !== e) begin n_fail++; $display("FAIL async_rst_rdata: got %h expected %h", readdata, e); end
    tick(3);
    reset_n = 1'b1;
    exp_q.push_back(32'h0);
    tick(40);
    e = exp_q.pop_front(); n_checks++;
    if ({24'h0, led} !== e) begin n_fail++; $display("FAIL post_rst_led: got %h expected %h", led, e); end
    exp_q.push_back(32'h0);
    bus_read(A_STATUS, rd);
    e = exp_q.pop_front(); n_checks++;
    if (rd !== e) begin n_fail++; $display("FAIL post_rst_status: got %h expected %h", rd, e); end
    exp_q.push_back(32'd250);
    bus_read(A_PERIOD, rd);
    e = exp_q.pop_front(); n_checks++;
    if (rd !== e) begin n_fail++; $display("FAIL post_rst_period: got %h expected %h", rd, e); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; address = '0; read = 1'b0; write = 1'b0;
    writedata = '0; btn = 4'hF;
    tick(3);
    reset_n = 1'b1;
    test_reset();
    test_manual();
    test_rotate();
    test_bounce();
    test_pause();
    test_back_to_back();
    test_counter_blink();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
